adsr_gate_sequencer: RTL and testbench

- Step sequencer that drives the gate/trigger of the ADSR envelope generator in the signal-generator design.
- Plays a programmable table of STEPS entries; each entry holds an enable bit, a gate length and a rest length in ticks.
- Optionally waits for the envelope to finish its release before advancing.
- Sits between the control plane (encoder/register writes) and adsr_generator; the gate starts attack, and gate low starts release.

---
 rtl/adsr_gate_sequencer.sv | 170 +++++++++++++++++
 tb/tb_adsr_gate_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_gate_sequencer.sv
// Step sequencer driving the ADSR envelope gate/trigger from a programmable
// table of {enable, gate length, rest length} entries measured in ticks.
module adsr_gate_sequencer #(
   parameter int unsigned STEPS    = 8,
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned LW       = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       abort,
   input  logic                       wait_rel,
   input  logic                       env_idle,
   input  logic                       wr_en,
   input  logic [$clog2(STEPS)-1:0]   wr_addr,
   input  logic [2*LW:0]              wr_data,
   output logic                       gate,
   output logic                       trig,
   output logic [$clog2(STEPS)-1:0]   step_idx,
   output logic                       step_done,
   output logic                       busy
);

   localparam int unsigned SW = $clog2(STEPS);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW = 2 * LW + 1;
   localparam int unsigned CW = LW + 1;
   localparam logic [DW-1:0] RST_ENTRY = {1'b1, LW'(4), LW'(4)};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GATE,
      S_REST,
      S_HOLD,
      S_ADV
   } state_t;

   state_t          r_state;
   state_t          w_nxt;
   logic [DW-1:0]   r_tab [STEPS];
   logic [PW-1:0]   r_pre;
   logic [CW-1:0]   r_left;
   logic [CW-1:0]   r_rest;
   logic [SW-1:0]   r_step_idx;
   logic            r_gate;
   logic            r_trig;
   logic            r_step_done;
   logic            r_busy;

   logic [DW-1:0]   w_ent;
   logic            w_en;
   logic [LW-1:0]   w_glen;
   logic [LW-1:0]   w_rlen;
   logic [CW-1:0]   w_g;
   logic [CW-1:0]   w_r;
   logic [CW-1:0]   w_load_len;
   logic [CW-1:0]   w_rest_len;
   logic            w_tick;
   logic            w_last;
   logic            w_gate_nxt;
   logic            w_trig_nxt;
   logic            w_done_nxt;
   logic            w_busy_nxt;

   // Entry of the current step; zero lengths are stretched to one tick
   assign w_ent      = r_tab[r_step_idx];
   assign w_en       = w_ent[DW-1];
   assign w_glen     = w_ent[DW-2:LW];
   assign w_rlen     = w_ent[LW-1:0];
   assign w_g        = (w_glen == '0) ? CW'(1) : CW'(w_glen);
   assign w_r        = (w_rlen == '0) ? CW'(1) : CW'(w_rlen);
   assign w_load_len = w_en ? w_g : (w_g + w_r);
   assign w_rest_len = w_en ? w_r : (w_g + w_r);
   assign w_tick     = (r_pre == PW'(TICK_DIV - 1));
   assign w_last     = w_tick && (r_left == CW'(1));

   // Next state and next registered outputs
   always_comb begin
      w_nxt      = r_state;
      w_gate_nxt = 1'b0;
      w_trig_nxt = 1'b0;
      w_done_nxt = 1'b0;
      w_busy_nxt = 1'b0;
      case (r_state)
         S_IDLE: if (run) w_nxt = S_LOAD;
         S_LOAD: w_nxt = w_en ? S_GATE : S_REST;
         S_GATE: if (w_last) w_nxt = S_REST;
         S_REST: if (w_last) w_nxt = (wait_rel && !env_idle) ? S_HOLD : S_ADV;
         S_HOLD: if (env_idle) w_nxt = S_ADV;
         S_ADV:  w_nxt = run ? S_LOAD : S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      if (abort) w_nxt = S_IDLE;
      w_gate_nxt = (w_nxt == S_GATE);
      w_trig_nxt = (r_state == S_LOAD) && (w_nxt == S_GATE);
      w_done_nxt = (w_nxt == S_ADV);
      w_busy_nxt = (w_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_gate      <= 1'b0;
         r_trig      <= 1'b0;
         r_step_done <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_gate      <= w_gate_nxt;
         r_trig      <= w_trig_nxt;
         r_step_done <= w_done_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Tick prescaler, restarted on every GATE/REST entry so lengths are exact
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         r_pre <= '0;
      end else if ((w_nxt == S_GATE && r_state != S_GATE) ||
                   (w_nxt == S_REST && r_state != S_REST)) begin
         r_pre <= '0;
      end else if (r_state != S_IDLE) begin
         r_pre <= w_tick ? '0 : (r_pre + PW'(1));
      end
   end

   // Remaining ticks in the current GATE or REST phase
   always_ff @(posedge clk) begin
      if (rst) begin
         r_left <= '0;
         r_rest <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_left <= w_load_len;
               r_rest <= w_rest_len;
            end
            S_GATE: begin
               if (w_last)      r_left <= r_rest;
               else if (w_tick) r_left <= r_left - CW'(1);
            end
            S_REST: if (w_tick) r_left <= r_left - CW'(1);
            default: r_left <= r_left;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || abort)           r_step_idx <= '0;
      else if (r_state == S_ADV)  r_step_idx <= r_step_idx + SW'(1);
   end

   // Step table; a write lands after the LOAD that reads the same entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < STEPS; i++) r_tab[i] <= RST_ENTRY;
      end else if (wr_en) begin
         r_tab[wr_addr] <= wr_data;
      end
   end

   assign gate      = r_gate;
   assign trig      = r_trig;
   assign step_idx  = r_step_idx;
   assign step_done = r_step_done;
   assign busy      = r_busy;

endmodule

// File: tb/tb_adsr_gate_sequencer.sv
// Self-checking bench for adsr_gate_sequencer: per-step timing is predicted
// from table contents with plain arithmetic and compared with observed cycles.
module tb_adsr_gate_sequencer;

   localparam int unsigned STEPS = 8;
   localparam int unsigned TICK  = 4;
   localparam int unsigned LW    = 8;
   localparam int unsigned SW    = $clog2(STEPS);
   localparam int unsigned DW    = 2 * LW + 1;

   logic           clk      = 1'b0;
   logic           rst      = 1'b1;
   logic           run      = 1'b0;
   logic           abort    = 1'b0;
   logic           wait_rel = 1'b0;
   logic           env_idle = 1'b1;
   logic           wr_en    = 1'b0;
   logic [SW-1:0]  wr_addr  = '0;
   logic [DW-1:0]  wr_data  = '0;
   logic           gate;
   logic           trig;
   logic [SW-1:0]  step_idx;
   logic           step_done;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] m_tab [STEPS];
   int            m_idx;

   always #5 clk = ~clk;

   adsr_gate_sequencer #(.STEPS(STEPS), .TICK_DIV(TICK), .LW(LW)) dut (
      .clk(clk), .rst(rst), .run(run), .abort(abort), .wait_rel(wait_rel),
      .env_idle(env_idle), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .gate(gate), .trig(trig), .step_idx(step_idx), .step_done(step_done),
      .busy(busy)
   );

   // Reference model: a step is LOAD + gate ticks + rest ticks + ADV
   function automatic logic [DW-1:0] mk(input logic en, input int g, input int r);
      return {en, LW'(g), LW'(r)};
   endfunction

   function automatic int len1(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int exp_hi(input logic [DW-1:0] e);
      return e[DW-1] ? TICK * len1(int'(e[DW-2:LW])) : 0;
   endfunction

   function automatic int exp_tot(input logic [DW-1:0] e);
      return 2 + TICK * (len1(int'(e[DW-2:LW])) + len1(int'(e[LW-1:0])));
   endfunction

   function automatic int exp_trg(input logic [DW-1:0] e);
      return e[DW-1] ? 1 : 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; abort = 1'b0; wait_rel = 1'b0;
      env_idle = 1'b1; wr_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < int'(STEPS); i++) m_tab[i] = mk(1'b1, 4, 4);
      m_idx = 0;
   endtask

   task automatic wr(input int addr, input logic [DW-1:0] data);
      wr_en = 1'b1; wr_addr = SW'(addr); wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Observe one step from its LOAD cycle through its step_done cycle
   task automatic measure_step(input int drop_at, input int wr_at, input int waddr,
                               input logic [DW-1:0] wdata, output int hi,
                               output int tot, output int trg, output int idx);
      bit done = 1'b0;
      hi = 0; tot = 0; trg = 0; idx = -1;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         wr_en = 1'b0;
         tot++;
         if (gate) hi++;
         if (trig) trg++;
         if (step_done) begin
            idx  = int'(step_idx);
            done = 1'b1;
         end else begin
            if (tot == drop_at) run = 1'b0;
            if (tot == wr_at) begin
               wr_en = 1'b1; wr_addr = SW'(waddr); wr_data = wdata;
            end
         end
      end
      wr_en = 1'b0;
      if (!done) begin
         failures++;
         $display("FAIL step_timeout: no step_done within 3000 cycles");
      end
   endtask

   task automatic test_reset();
      do_reset();
      wr(0, mk(1'b1, 9, 9));
      do_reset();
      checks++; if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got %b want 0", gate); end
      checks++; if (trig !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b want 0", trig); end
      checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", step_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (step_idx !== 3'd0) begin failures++; $display("FAIL reset_idx: got %0d want 0", step_idx); end
   endtask

   task automatic test_first_step();
      int hi, tot, trg, idx;
      repeat (7) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
      run = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || gate !== 1'b0) begin
         failures++; $display("FAIL load_cycle: got busy=%b gate=%b want busy=1 gate=0", busy, gate);
      end
      run = 1'b0;
      @(negedge clk);
      checks++; if (gate !== 1'b1 || trig !== 1'b1 || step_idx !== 3'd0) begin
         failures++; $display("FAIL first_gate: got gate=%b trig=%b idx=%0d want 1 1 0", gate, trig, step_idx);
      end
      measure_step(0, 0, 0, '0, hi, tot, trg, idx);
      checks++; if (hi !== exp_hi(m_tab[0]) - 1 || tot !== exp_tot(m_tab[0]) - 2 || trg !== 0 || idx !== 0) begin
         failures++; $display("FAIL first_step: got hi=%0d tot=%0d trig=%0d idx=%0d want %0d %0d 0 0",
                              hi, tot, trg, idx, exp_hi(m_tab[0]) - 1, exp_tot(m_tab[0]) - 2);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || step_idx !== 3'd1 || step_done !== 1'b0) begin
         failures++; $display("FAIL first_stop: got busy=%b idx=%0d done=%b want 0 1 0", busy, step_idx, step_done);
      end
   endtask

   task automatic test_disabled_step();
      int hi, tot, trg, idx;
      do_reset();
      wr(3, mk(1'b0, 2, 3));
      m_tab[3] = mk(1'b0, 2, 3);
      run = 1'b1;
      for (int s = 0; s < 5; s++) begin
         measure_step((s == 4) ? 2 : 0, 0, 0, '0, hi, tot, trg, idx);
         checks++;
         if (hi !== exp_hi(m_tab[m_idx]) || tot !== exp_tot(m_tab[m_idx]) ||
             trg !== exp_trg(m_tab[m_idx]) || idx !== m_idx) begin
            failures++;
            $display("FAIL disabled_step s=%0d: got hi=%0d tot=%0d trig=%0d idx=%0d want %0d %0d %0d %0d",
                     s, hi, tot, trg, idx, exp_hi(m_tab[m_idx]), exp_tot(m_tab[m_idx]),
                     exp_trg(m_tab[m_idx]), m_idx);
         end
         m_idx = (m_idx + 1) % int'(STEPS);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || int'(step_idx) !== m_idx) begin
         failures++; $display("FAIL disabled_stop: got busy=%b idx=%0d want 0 %0d", busy, step_idx, m_idx);
      end
   endtask

   task automatic test_gate_len_zero();
      int hi, tot, trg, idx;
      do_reset();
      wr(0, mk(1'b1, 0, 0));
      m_tab[0] = mk(1'b1, 0, 0);
      run = 1'b1;
      for (int s = 0; s < 9; s++) begin
         measure_step((s == 8) ? 3 : 0, 0, 0, '0, hi, tot, trg, idx);
         checks++;
         if (hi !== exp_hi(m_tab[m_idx]) || tot !== exp_tot(m_tab[m_idx]) ||
             trg !== exp_trg(m_tab[m_idx]) || idx !== m_idx) begin
            failures++;
            $display("FAIL wrap_step s=%0d: got hi=%0d tot=%0d trig=%0d idx=%0d want %0d %0d %0d %0d",
                     s, hi, tot, trg, idx, exp_hi(m_tab[m_idx]), exp_tot(m_tab[m_idx]),
                     exp_trg(m_tab[m_idx]), m_idx);
         end
         m_idx = (m_idx + 1) % int'(STEPS);
      end
      checks++; if (hi !== 4 || trg !== 1 || idx !== 0) begin
         failures++; $display("FAIL zero_len_wrap: got hi=%0d trig=%0d idx=%0d want 4 1 0", hi, trg, idx);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || step_idx !== 3'd1) begin
         failures++; $display("FAIL wrap_stop: got busy=%b idx=%0d want 0 1", busy, step_idx);
      end
   endtask

   task automatic test_random_table();
      int hi, tot, trg, idx, wat;
      logic [DW-1:0] nd;
      do_reset();
      for (int i = 0; i < int'(STEPS); i++) begin
         nd = mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
         wr(i, nd);
         m_tab[i] = nd;
      end
      wait_rel = 1'($urandom_range(0, 1));
      run = 1'b1;
      for (int s = 0; s < 12; s++) begin
         nd  = mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
         wat = int'($urandom_range(1, 3));
         measure_step((s == 11) ? int'($urandom_range(2, 5)) : 0, wat, m_idx, nd, hi, tot, trg, idx);
         checks++;
         if (hi !== exp_hi(m_tab[m_idx]) || tot !== exp_tot(m_tab[m_idx]) ||
             trg !== exp_trg(m_tab[m_idx]) || idx !== m_idx) begin
            failures++;
            $display("FAIL random_step s=%0d: got hi=%0d tot=%0d trig=%0d idx=%0d want %0d %0d %0d %0d",
                     s, hi, tot, trg, idx, exp_hi(m_tab[m_idx]), exp_tot(m_tab[m_idx]),
                     exp_trg(m_tab[m_idx]), m_idx);
         end
         m_tab[m_idx] = nd;
         m_idx = (m_idx + 1) % int'(STEPS);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || int'(step_idx) !== m_idx) begin
         failures++; $display("FAIL random_stop: got busy=%b idx=%0d want 0 %0d", busy, step_idx, m_idx);
      end
      wait_rel = 1'b0;
   endtask

   task automatic test_wait_rel();
      int viol = 0;
      int hold_n;
      do_reset();
      wait_rel = 1'b1;
      env_idle = 1'b0;
      run = 1'b1;
      for (int c = 0; c < 1 + 2 * 4 * int'(TICK); c++) begin
         @(negedge clk);
         run = 1'b0;
         if (step_done !== 1'b0) viol++;
      end
      hold_n = int'($urandom_range(40, 60));
      for (int c = 0; c < hold_n; c++) begin
         @(negedge clk);
         if (step_done !== 1'b0 || gate !== 1'b0 || busy !== 1'b1) viol++;
      end
      checks++; if (viol !== 0) begin
         failures++; $display("FAIL hold_wait: got %0d bad cycles want 0", viol);
      end
      env_idle = 1'b1;
      @(negedge clk);
      checks++; if (step_done !== 1'b1 || step_idx !== 3'd0) begin
         failures++; $display("FAIL hold_release: got done=%b idx=%0d want 1 0", step_done, step_idx);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || step_done !== 1'b0 || step_idx !== 3'd1) begin
         failures++; $display("FAIL hold_after: got busy=%b done=%b idx=%0d want 0 0 1", busy, step_done, step_idx);
      end
      wait_rel = 1'b0;
   endtask

   task automatic test_abort();
      int hi, tot, trg, idx;
      int viol = 0;
      do_reset();
      run = 1'b1;
      for (int s = 0; s < 5; s++) begin
         measure_step(0, 0, 0, '0, hi, tot, trg, idx);
         checks++; if (tot !== exp_tot(m_tab[s]) || idx !== s) begin
            failures++; $display("FAIL abort_pre s=%0d: got tot=%0d idx=%0d want %0d %0d",
                                 s, tot, idx, exp_tot(m_tab[s]), s);
         end
      end
      repeat (1 + int'($urandom_range(1, 10))) @(negedge clk);
      checks++; if (gate !== 1'b1 || step_idx !== 3'd5) begin
         failures++; $display("FAIL abort_setup: got gate=%b idx=%0d want 1 5", gate, step_idx);
      end
      abort = 1'b1;
      @(negedge clk);
      checks++; if (gate !== 1'b0 || trig !== 1'b0 || step_idx !== 3'd0 || busy !== 1'b0 || step_done !== 1'b0) begin
         failures++; $display("FAIL abort_now: got gate=%b trig=%b idx=%0d busy=%b done=%b want all 0",
                              gate, trig, step_idx, busy, step_done);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy !== 1'b0 || gate !== 1'b0 || step_done !== 1'b0) viol++;
      end
      checks++; if (viol !== 0) begin
         failures++; $display("FAIL abort_hold: got %0d busy cycles want 0", viol);
      end
      abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (trig !== 1'b1 || step_idx !== 3'd0) begin
         failures++; $display("FAIL abort_restart: got trig=%b idx=%0d want 1 0", trig, step_idx);
      end
   endtask

   task automatic test_run_drop();
      int hi, tot, trg, idx;
      do_reset();
      run = 1'b1;
      for (int s = 0; s < 3; s++) begin
         measure_step((s == 2) ? int'($urandom_range(3, 12)) : 0, 0, 0, '0, hi, tot, trg, idx);
         checks++; if (hi !== exp_hi(m_tab[s]) || tot !== exp_tot(m_tab[s]) || idx !== s) begin
            failures++; $display("FAIL run_drop s=%0d: got hi=%0d tot=%0d idx=%0d want %0d %0d %0d",
                                 s, hi, tot, idx, exp_hi(m_tab[s]), exp_tot(m_tab[s]), s);
         end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || step_idx !== 3'd3) begin
         failures++; $display("FAIL run_drop_stop: got busy=%b idx=%0d want 0 3", busy, step_idx);
      end
      repeat (5) @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (trig !== 1'b1 || gate !== 1'b1 || step_idx !== 3'd3) begin
         failures++; $display("FAIL run_resume: got trig=%b gate=%b idx=%0d want 1 1 3", trig, gate, step_idx);
      end
      run = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_step();
      test_disabled_step();
      test_gate_len_zero();
      test_random_table();
      test_wait_rel();
      test_abort();
      test_run_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
